// File: rtl/e203_itcm_icb_sram_ctrl_if.sv
// Single-beat ICB command/response bundle between the IFU and the ITCM controller.
// master drives commands and rsp_ready; slave answers with cmd_ready and the response.
interface e203_itcm_icb_sram_ctrl_if #(
    parameter int DW = 64,
    parameter int AW = 16
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/e203_itcm_icb_sram_ctrl.sv
// ITCM controller: single-beat ICB slave in front of a 1-cycle-latency single-port SRAM.
// Also tracks whether sram_dout still holds the last read word (holdup).
module e203_itcm_icb_sram_ctrl #(
    parameter int DW    = 64,
    parameter int AW    = 16,
    parameter int DEPTH = 4096,
    localparam int BW   = DW / 8,
    localparam int SAW  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    e203_itcm_icb_sram_ctrl_if.slave icb,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic [SAW-1:0]          sram_addr,
    output logic [BW-1:0]           sram_wem,
    output logic [DW-1:0]           sram_din,
    input  logic [DW-1:0]           sram_dout,
    output logic                    holdup,
    output logic [SAW-1:0]          holdup_addr
);
    localparam int LSB = $clog2(BW);
    localparam longint unsigned LIMIT = longint'(DEPTH) * longint'(BW);

    typedef enum logic {IDLE = 1'b0, RSP = 1'b1} state_t;

    state_t         state_reg;
    logic           is_read_reg;
    logic           err_reg;
    logic           first_reg;
    logic [DW-1:0]  hold_reg;
    logic           holdup_reg;
    logic [SAW-1:0] holdup_addr_reg;

    logic cmd_ready;
    logic cmd_hs;
    logic rsp_hs;
    logic in_range;
    logic sram_go;

    assign in_range  = (64'(icb.icb_cmd_addr) < LIMIT);
    assign cmd_ready = (state_reg == IDLE) | icb.icb_rsp_ready;
    assign cmd_hs    = icb.icb_cmd_valid & cmd_ready;
    assign rsp_hs    = (state_reg == RSP) & icb.icb_rsp_ready;
    // The SRAM is never touched while reset is asserted, even if a command shakes hands.
    assign sram_go   = cmd_hs & in_range & ~rst;

    assign sram_cs   = sram_go;
    assign sram_we   = sram_go & ~icb.icb_cmd_read;
    assign sram_addr = sram_go ? icb.icb_cmd_addr[LSB +: SAW] : '0;
    assign sram_din  = sram_go ? icb.icb_cmd_wdata : '0;

    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_wem
            assign sram_wem[gi] = sram_go & ~icb.icb_cmd_read & icb.icb_cmd_wmask[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            is_read_reg     <= 1'b0;
            err_reg         <= 1'b0;
            first_reg       <= 1'b0;
            hold_reg        <= '0;
            holdup_reg      <= 1'b0;
            holdup_addr_reg <= '0;
        end else begin
            if (cmd_hs) begin
                state_reg   <= RSP;
                is_read_reg <= icb.icb_cmd_read;
                err_reg     <= ~in_range;
                first_reg   <= 1'b1;
            end else begin
                if (rsp_hs) begin
                    state_reg <= IDLE;
                end
                first_reg <= 1'b0;
            end

            // sram_dout is only guaranteed in the first response cycle; keep a copy if stalled.
            if ((state_reg == RSP) && first_reg && is_read_reg && !err_reg && !icb.icb_rsp_ready) begin
                hold_reg <= sram_dout;
            end

            if (sram_go) begin
                if (icb.icb_cmd_read) begin
                    holdup_reg      <= 1'b1;
                    holdup_addr_reg <= sram_addr;
                end else begin
                    holdup_reg      <= 1'b0;
                end
            end
        end
    end

    assign icb.icb_cmd_ready = cmd_ready;
    assign icb.icb_rsp_valid = (state_reg == RSP);
    assign icb.icb_rsp_err   = err_reg;
    assign holdup            = holdup_reg;
    assign holdup_addr       = holdup_addr_reg;

    always_comb begin
        icb.icb_rsp_rdata = '0;
        if ((state_reg == RSP) && is_read_reg && !err_reg) begin
            icb.icb_rsp_rdata = first_reg ? sram_dout : hold_reg;
        end
    end
endmodule

// File: doc/e203_itcm_icb_sram_ctrl.md
Name: e203_itcm_icb_sram_ctrl

Overview:
- ICB-slave-to-SRAM controller for the ITCM. It sits directly upstream of the core's ifu2itcm ICB port.
- Accepts single-beat ICB commands, drives a 1-cycle-latency single-port SRAM, and returns responses on ifu2itcm_icb_rsp_valid/err/rdata (64-bit).
- Produces the ifu2itcm_holdup indication: the SRAM output still holds the last read data.

Parameters:
- DW, 64, data width in bits; byte lanes = DW/8.
- AW, 16, ICB byte-address width.
- DEPTH, 4096, SRAM words; SRAM address width = log2(DEPTH).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  DW/8  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_err  out  1  address-range error
- icb_rsp_rdata  out  DW  read data
- sram_cs  out  1  chip select
- sram_we  out  1  write enable
- sram_addr  out  log2(DEPTH)  word address
- sram_wem  out  DW/8  byte write mask
- sram_din  out  DW  write data
- sram_dout  in  DW  read data, valid the cycle after a read cs
- holdup  out  1  sram_dout still equals data of last SRAM read
- holdup_addr  out  log2(DEPTH)  word address of that read

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM=IDLE, icb_rsp_valid=0, icb_rsp_err=0, hold register=0, holdup=0, holdup_addr=0.
- Reset mid-response discards the pending response; no SRAM access occurs in a reset cycle.
- FSM has two states:
  - IDLE: no pending response.
  - RSP: response pending; icb_rsp_valid=1.
- Handshake:
  - icb_cmd_ready = (state==IDLE) | icb_rsp_ready. A new command is accepted in the same cycle the current response drains.
  - cmd_hs = valid & ready.
  - cmd_hs moves the FSM to RSP.
  - Response handshake without a new cmd_hs moves the FSM to IDLE.
  - Both in the same cycle: the FSM stays in RSP with the new response.
- Range check: in_range = icb_cmd_addr < DEPTH*DW/8.
- SRAM drive on cmd_hs & in_range & !rst (combinational, same cycle):
  - sram_cs=1, sram_we=!read.
  - sram_addr = addr[AW-1:log2(DW/8)], truncated to SRAM address width.
  - sram_wem = read ? 0 : wmask; sram_din = wdata.
- Otherwise: all SRAM outputs are 0.
- Response latency is exactly 1 cycle after cmd_hs. Registered per response:
  - is_read
  - err = !in_range
  - first-cycle flag
- icb_rsp_rdata:
  - err or write: 0.
  - Read, first RSP cycle: sram_dout.
  - Read, later cycles: the hold register.
- Hold register: captures sram_dout in the first RSP cycle of a read when icb_rsp_ready=0. rdata stays stable under backpressure.
- Out-of-range command: no SRAM access; response err=1, rdata=0; holdup unchanged.
- holdup register:
  - Set to 1, with holdup_addr=sram_addr, in the cycle after a read cs.
  - Cleared in the cycle after a write cs.
  - Unchanged otherwise.
- wmask=0 on a write still asserts cs and we, which clears holdup.

Test Plan:
- Write addr 0x0010, wdata 0x1122334455667788, wmask 0xFF, rsp_ready=1 -> same cycle: cs=1, we=1, sram_addr=2, wem=0xFF. Next cycle: rsp_valid=1, err=0, rdata=0.
- Read 0x0010 with SRAM returning 0x1122334455667788 -> rsp one cycle later with that rdata. holdup=1, holdup_addr=2. A following write to 0x0018 clears holdup.
- Read with rsp_ready held 0 for 3 cycles while the SRAM model changes dout to 0xDEAD -> rdata stays 0x1122334455667788, icb_cmd_ready=0, no further cs.
- Back-to-back reads 0x0000, 0x0008 with rsp_ready=1 -> both accepted on consecutive cycles, one response per cycle, rsp_valid continuously 1.
- Read addr 0x8000 -> no cs, rsp err=1, rdata=0, holdup unchanged.
- rst=1 while in RSP -> next cycle rsp_valid=0, holdup=0, cmd_ready=1.
